// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_event_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO; head word read straight from storage.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_scan_fifo.sv
// PS/2 device-to-host receiver: sync/filter, frame check, E0/F0 folding, event FIFO.
module ps2_scan_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        SCLK,
    input  logic                        SDATA,
    output logic                        EV_VALID,
    input  logic                        EV_READY,
    output logic [7:0]                  EV_CODE,
    output logic                        EV_BREAK,
    output logic                        EV_EXT,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                        PAR_ERR,
    output logic                        FRM_ERR,
    output logic                        OVF,
    output logic [7:0]                  ERR_CNT
);
    localparam int unsigned   FL_W   = $clog2(FILTER_LEN + 1);
    localparam logic [FL_W-1:0] FL_MAX = FL_W'(FILTER_LEN - 1);
    localparam int unsigned   TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sdata_sync_q;
    logic [FL_W-1:0]        sclk_cnt_q, sdata_cnt_q;
    logic                   sclk_flt_q, sdata_flt_q, sclk_prev_q;
    logic                   fall;

    ps2_state_e  state_q;
    logic [2:0]  bitcnt_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [TO_W-1:0] to_cnt_q;
    logic        ext_q, brk_q, push_q, par_err_q, frm_err_q, ovf_q;
    ps2_event_t  ev_q, head_ev;
    logic [7:0]  err_cnt_q;
    logic [8:0]  err_sum;
    logic        fifo_full, fifo_empty;

    // Filtered lines flip only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_sync_q  <= '1;
            sdata_sync_q <= '1;
            sclk_cnt_q   <= '0;
            sdata_cnt_q  <= '0;
            sclk_flt_q   <= 1'b1;
            sdata_flt_q  <= 1'b1;
            sclk_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], SDATA};
            sclk_prev_q  <= sclk_flt_q;
            if (sclk_sync_q[SYNC_STAGES-1] == sclk_flt_q) begin
                sclk_cnt_q <= '0;
            end else if (sclk_cnt_q == FL_MAX) begin
                sclk_flt_q <= ~sclk_flt_q;
                sclk_cnt_q <= '0;
            end else begin
                sclk_cnt_q <= sclk_cnt_q + FL_W'(1);
            end
            if (sdata_sync_q[SYNC_STAGES-1] == sdata_flt_q) begin
                sdata_cnt_q <= '0;
            end else if (sdata_cnt_q == FL_MAX) begin
                sdata_flt_q <= ~sdata_flt_q;
                sdata_cnt_q <= '0;
            end else begin
                sdata_cnt_q <= sdata_cnt_q + FL_W'(1);
            end
        end
    end

    assign fall = sclk_prev_q & ~sclk_flt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            push_q    <= 1'b0;
            ev_q      <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            if (fall) begin
                to_cnt_q <= '0;
            end else if (state_q != IDLE) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (fall && !sdata_flt_q) begin
                        state_q  <= DATA;
                        bitcnt_q <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shift_q  <= {sdata_flt_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= PARITY;
                    end
                end
                PARITY: begin
                    if (fall) begin
                        par_q   <= sdata_flt_q;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state_q <= IDLE;
                        if (!sdata_flt_q) begin
                            frm_err_q <= 1'b1;
                            ext_q     <= 1'b0;
                            brk_q     <= 1'b0;
                        end else if (!(^{shift_q, par_q})) begin
                            par_err_q <= 1'b1;
                            ext_q     <= 1'b0;
                            brk_q     <= 1'b0;
                        end else if (shift_q == PS2_PREFIX_EXT) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == PS2_PREFIX_BRK) begin
                            brk_q <= 1'b1;
                        end else begin
                            push_q <= 1'b1;
                            ev_q   <= '{code: shift_q, brk: brk_q, ext: ext_q};
                            ext_q  <= 1'b0;
                            brk_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Timeout overrides any in-frame progress: no edge arrived this cycle anyway.
            if (state_q != IDLE && !fall && to_cnt_q == TO_MAX) begin
                state_q   <= IDLE;
                to_cnt_q  <= '0;
                frm_err_q <= 1'b1;
                ext_q     <= 1'b0;
                brk_q     <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH($bits(ps2_event_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push_q),
        .wdata_i (ev_q),
        .pop_i   (EV_READY),
        .rdata_o (head_ev),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (FIFO_LEVEL)
    );

    assign err_sum = {1'b0, err_cnt_q} + {8'd0, par_err_q} + {8'd0, frm_err_q} + {8'd0, ovf_q};

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            ovf_q     <= push_q & fifo_full & ~EV_READY;
            err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign EV_VALID = ~fifo_empty;
    assign EV_CODE  = head_ev.code;
    assign EV_BREAK = head_ev.brk;
    assign EV_EXT   = head_ev.ext;
    assign PAR_ERR  = par_err_q;
    assign FRM_ERR  = frm_err_q;
    assign OVF      = ovf_q;
    assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Directed plus randomized bench for ps2_scan_fifo against a queue-based event model.
module tb_ps2_scan_fifo;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_LEN  = 4;
    localparam int unsigned TIMEOUT_CYC = 300;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int          H           = 20;

    logic       CLK = 1'b0;
    logic       RST, SCLK, SDATA, EV_READY;
    logic       EV_VALID, EV_BREAK, EV_EXT, PAR_ERR, FRM_ERR, OVF;
    logic [7:0] EV_CODE, ERR_CNT;
    logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL;

    always #5 CLK = ~CLK;

    ps2_scan_fifo #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SCLK       (SCLK),
        .SDATA      (SDATA),
        .EV_VALID   (EV_VALID),
        .EV_READY   (EV_READY),
        .EV_CODE    (EV_CODE),
        .EV_BREAK   (EV_BREAK),
        .EV_EXT     (EV_EXT),
        .FIFO_LEVEL (FIFO_LEVEL),
        .PAR_ERR    (PAR_ERR),
        .FRM_ERR    (FRM_ERR),
        .OVF        (OVF),
        .ERR_CNT    (ERR_CNT)
    );

    int checks = 0;
    int errors = 0;

    // Observation side: pulse counts and every handshaken event.
    int         n_par = 0, n_frm = 0, n_ovf = 0, rx_n = 0;
    logic [9:0] rx_mem [0:1023];

    always @(negedge CLK) begin
        if (PAR_ERR === 1'b1) n_par <= n_par + 1;
        if (FRM_ERR === 1'b1) n_frm <= n_frm + 1;
        if (OVF === 1'b1)     n_ovf <= n_ovf + 1;
        if (RST === 1'b0 && EV_VALID === 1'b1 && EV_READY === 1'b1 && rx_n < 1024) begin
            rx_mem[rx_n] <= {EV_CODE, EV_BREAK, EV_EXT};
            rx_n         <= rx_n + 1;
        end
    end

    // Reference model state.
    logic [9:0] exp_q [$];
    bit m_ext, m_brk, hold, rnd_ready;
    int m_par, m_frm, m_ovf, m_level;
    int base_par, base_frm, base_ovf, rx_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_ext = 0; m_brk = 0;
        m_par = 0; m_frm = 0; m_ovf = 0; m_level = 0;
        base_par = n_par; base_frm = n_frm; base_ovf = n_ovf;
        rx_rd = rx_n;
    endtask

    task automatic ref_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        if (bad_stop) begin
            m_frm++; m_ext = 0; m_brk = 0;
        end else if (bad_par) begin
            m_par++; m_ext = 0; m_brk = 0;
        end else if (d == 8'hE0) begin
            m_ext = 1;
        end else if (d == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (hold && m_level >= FIFO_DEPTH) begin
                m_ovf++;
            end else begin
                exp_q.push_back({d, m_brk, m_ext});
                if (hold) m_level++;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; SCLK = 1'b1; SDATA = 1'b1;
        tick(4);
        RST = 1'b0;
        tick(2);
        model_clear();
    endtask

    task automatic put_bit(input bit b, input bit glitch);
        SDATA = b;
        if (rnd_ready) EV_READY = 1'($urandom_range(0, 1));
        if (glitch) begin
            tick(8); SCLK = 1'b0; tick(2); SCLK = 1'b1; tick(H - 10);
        end else begin
            tick(H);
        end
        SCLK = 1'b0;
        tick(H);
        SCLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int glitch_bit);
        put_bit(1'b0, glitch_bit == 0);
        for (int i = 0; i < 8; i++) put_bit(d[i], glitch_bit == i + 1);
        put_bit(~(^d) ^ bad_par, glitch_bit == 9);
        put_bit(~bad_stop, glitch_bit == 10);
        SDATA = 1'b1;
        tick(H);
        ref_frame(d, bad_par, bad_stop);
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        put_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) put_bit(d[i], 1'b0);
    endtask

    task automatic check_all(input string tag);
        int got;
        int tot;
        got = rx_n - rx_rd;
        check({tag, " n_events"}, got, exp_q.size());
        for (int i = 0; i < got && i < exp_q.size(); i++)
            check({tag, " event"}, rx_mem[rx_rd + i], exp_q[i]);
        rx_rd = rx_n;
        exp_q.delete();
        check({tag, " par_pulses"}, n_par - base_par, m_par);
        check({tag, " frm_pulses"}, n_frm - base_frm, m_frm);
        check({tag, " ovf_pulses"}, n_ovf - base_ovf, m_ovf);
        tot = m_par + m_frm + m_ovf;
        check({tag, " err_cnt"}, ERR_CNT, (tot > 255) ? 255 : tot);
    endtask

    initial begin
        logic [7:0] held_code;
        logic [7:0] d;
        RST = 1'b1; SCLK = 1'b1; SDATA = 1'b1; EV_READY = 1'b1;
        hold = 0; rnd_ready = 0;
        model_clear();
        do_reset();
        check("rst ev_valid", EV_VALID, 0);
        check("rst level", FIFO_LEVEL, 0);
        check("rst err_cnt", ERR_CNT, 0);
        check("rst pulses", {PAR_ERR, FRM_ERR, OVF}, 0);
        check("rst head", {EV_CODE, EV_BREAK, EV_EXT}, 0);

        send_frame(8'h1C, 0, 0, -1);
        check_all("single");

        do_reset();
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h1C, 0, 0, -1);
        send_frame(8'hE0, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h75, 0, 0, -1);
        send_frame(8'h32, 0, 0, -1);
        check_all("prefix");

        do_reset();
        send_frame(8'h1C, 1, 0, -1);
        send_frame(8'h32, 0, 0, -1);
        check_all("parity");

        do_reset();
        send_frame(8'hE0, 0, 0, -1);
        send_partial(8'h5A, 4);
        tick(TIMEOUT_CYC + 10 + 20);
        m_frm++; m_ext = 0; m_brk = 0;
        send_frame(8'h1C, 0, 0, -1);
        check_all("timeout");

        do_reset();
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h1C, 1, 1, -1);
        send_frame(8'h2B, 0, 0, -1);
        check_all("stop_err");

        do_reset();
        send_partial(8'h33, 5);
        do_reset();
        send_frame(8'h32, 0, 0, -1);
        check_all("mid_reset");

        do_reset();
        hold = 1; EV_READY = 1'b0;
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 0, 0, -1);
        check("ovf level", FIFO_LEVEL, m_level);
        check("ovf valid", EV_VALID, m_level != 0);
        held_code = EV_CODE;
        tick(5);
        check("ovf head", held_code, exp_q[0][9:2]);
        check("ovf stable", EV_CODE, exp_q[0][9:2]);
        EV_READY = 1'b1; hold = 0; m_level = 0;
        tick(20);
        check("ovf drained", FIFO_LEVEL, 0);
        check_all("overflow");

        do_reset();
        SCLK = 1'b0; tick(2); SCLK = 1'b1; tick(10);
        send_frame(8'h5A, 0, 0, 3);
        send_frame(8'h29, 0, 0, 9);
        send_frame(8'h4D, 0, 0, 0);
        check_all("glitch");

        do_reset();
        rnd_ready = 1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0:       d = 8'hE0;
                1:       d = 8'hF0;
                default: d = 8'($urandom_range(0, 255));
            endcase
            send_frame(d, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
        end
        rnd_ready = 0; EV_READY = 1'b1;
        tick(30);
        check_all("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
